systolic_array_controller: RTL
==============================

// Module: systolic_array_controller
// PURPOSE
//  Sequencer for an N x N systolic array of 8-bit PE cells (weight/subject/calc registers feeding a multiply-add).
//  On start it clears the array, loads N weight rows, streams K subject vectors with per-row skew, then drains.
//  It flags which column outputs carry valid results, and with which vector index.
//  Sits between the operand buffers (weight RAM, subject RAM) and the array top; it holds no datapath arithmetic.
// PARAMETERS
//  N      4   array dimension (rows = cols); legal 2..16
//  AW     8   width of k_len and of every subject/result index
//  NW     $clog2(N)  width of w_rd_addr (localparam)
// PORTS
//  clk             in   1      rising-edge clock
//  clear           in   1      asynchronous reset, active-low
//  start           in   1      1-cycle request; honoured only in IDLE
//  k_len           in   AW     number of subject vectors K; sampled on accepted start
//  busy            out  1      high in every state except IDLE
//  done            out  1      1-cycle pulse on the cycle in DONE
//  pe_clear        out  1      active-high clear to all PE registers
//  weight_control  out  1      high while weight rows are being shifted in
//  w_rd_addr       out  NW     weight-buffer row address, valid while weight_control=1
//  subj_rd_en      out  N      per-row subject read enable (bit r = array row r)
//  subj_rd_addr    out  N*AW   per-row subject index, row r in bits [r*AW +: AW]
//  res_valid       out  N      per-column result-valid flag (bit c = array column c)
//  res_idx         out  N*AW   per-column vector index of the result, column c in bits [c*AW +: AW]
// BEHAVIOUR
//  Reset (clear=0, async): state=IDLE; every output 0; all counters and latched K cleared.
//  FSM: IDLE -> CLR -> LOAD_W -> RUN -> DONE -> IDLE; each arrow fires on a clock edge.
//   IDLE  : start=1 latches K=k_len and enters CLR. With start=0 it stays in IDLE.
//   CLR   : one cycle; pe_clear=1.
//   LOAD_W: N cycles; weight_control=1; w_rd_addr = 0,1,...,N-1. After the last row, go to RUN.
//           If K==0, go to DONE instead and skip RUN.
//   RUN   : counter t = 0 .. K+2N-2, i.e. exactly K+2N-1 cycles, then DONE.
//           Row r: subj_rd_en[r] = (r <= t < K+r); subj_rd_addr[r] = t-r when enabled, else 0.
//           Column c: res_valid[c] = (N+c <= t < N+c+K); res_idx[c] = t-N-c when valid, else 0.
//   DONE  : one cycle; done=1; busy=1; then IDLE.
//  All outputs are registered: values listed for state/t appear during that state/t, with no combinational input-to-output path.
//  Latency from accepted start to done = 1 + N + (K+2N-1) + 1 cycles when K>0; = N+2 when K==0.
//  start while busy=1 is ignored (no queueing). start on the same edge that DONE returns to IDLE is also ignored.
//  k_len changes after acceptance have no effect. K=255 (AW=8) is legal: t width = AW+NW+1, so no wrap.
//  Indices never exceed K-1; a flag is never high outside its window; there are no partial-cycle glitches.
//  pe_clear is low in every state except CLR.
//  Reset mid-operation: immediate return to IDLE with all outputs 0; no done pulse.
// CONFIGURATION
//  SAC_ABORT_EN defined: adds input port abort (1 bit, after start).
//   abort=1 in CLR, LOAD_W or RUN -> next state DONE, and done pulses.
//   The same edge zeroes subj_rd_en, res_valid and weight_control.
//   abort in IDLE or DONE is ignored.
//   If start and abort are both high in IDLE, start wins.
//  SAC_ABORT_EN undefined: no abort port; a sequence always runs to completion.
// TESTING
//  1. Reset: clear=0 mid-RUN (N=4,K=3) -> all outputs 0 asynchronously; clear=1 then start -> normal run.
//  2. N=4, K=3: busy for 1+4+10+1=16 cycles. w_rd_addr 0..3 with weight_control high for 4 cycles.
//     subj_rd_en[3] high at t=3..5 with addr 0,1,2. res_valid[0] at t=4..6; res_valid[3] at t=7..9, idx 0,1,2.
//  3. K=0 -> CLR, 4 LOAD_W cycles, DONE; done exactly 6 cycles after start; subj_rd_en and res_valid never high.
//  4. start re-pulsed at every cycle while busy -> exactly one done. A second start 1 cycle after done -> second full run.
//  5. K=255, N=4 -> RUN lasts 262 cycles; res_idx[3] reaches 254 at t=261 with no wrap.
//  6. SAC_ABORT_EN, N=4, K=5, abort at t=2 -> next cycle done=1, res_valid=0, subj_rd_en=0; IDLE after that.

Source files
------------

// File: rtl/systolic_array_controller_if.sv
// Control/status bundle between the operand buffers, the systolic array and its sequencer.
// SAC_ABORT_EN adds the abort request.
interface systolic_array_controller_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 8
);
  localparam int unsigned NW = $clog2(N);

  logic              start;
  logic [AW-1:0]     k_len;
`ifdef SAC_ABORT_EN
  logic              abort;
`endif
  logic              busy;
  logic              done;
  logic              pe_clear;
  logic              weight_control;
  logic [NW-1:0]     w_rd_addr;
  logic [N-1:0]      subj_rd_en;
  logic [N*AW-1:0]   subj_rd_addr;
  logic [N-1:0]      res_valid;
  logic [N*AW-1:0]   res_idx;

`ifdef SAC_ABORT_EN
  modport master (
    output start, k_len, abort,
    input  busy, done, pe_clear, weight_control, w_rd_addr,
    input  subj_rd_en, subj_rd_addr, res_valid, res_idx
  );
  modport slave (
    input  start, k_len, abort,
    output busy, done, pe_clear, weight_control, w_rd_addr,
    output subj_rd_en, subj_rd_addr, res_valid, res_idx
  );
`else
  modport master (
    output start, k_len,
    input  busy, done, pe_clear, weight_control, w_rd_addr,
    input  subj_rd_en, subj_rd_addr, res_valid, res_idx
  );
  modport slave (
    input  start, k_len,
    output busy, done, pe_clear, weight_control, w_rd_addr,
    output subj_rd_en, subj_rd_addr, res_valid, res_idx
  );
`endif
endinterface

// File: rtl/systolic_array_controller.sv
// Sequencer for an N x N systolic array: clear, load N weight rows, stream K skewed vectors, drain.
// Optional SAC_ABORT_EN: abort in CLR/LOAD_W/RUN jumps straight to DONE.
module systolic_array_controller #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 8
) (
  input logic                   clk,
  input logic                   clear,
  systolic_array_controller_if.slave bus
);

  localparam int unsigned NW = $clog2(N);
  // Wide enough for t up to K+2N-2 with K at its maximum.
  localparam int unsigned TW = AW + NW + 1;

  typedef enum logic [2:0] {StIdle, StClr, StLoadW, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   k_q, k_d;
  logic [TW-1:0]   run_last;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pe_clear_q, pe_clear_d;
  logic            wc_q, wc_d;
  logic [NW-1:0]   wa_q, wa_d;
  logic [N-1:0]    sen_q, sen_d;
  logic [N*AW-1:0] sad_q, sad_d;
  logic [N-1:0]    rv_q, rv_d;
  logic [N*AW-1:0] ri_q, ri_d;

  assign run_last = TW'(k_q) + TW'(2 * N - 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StClr;
          k_d     = bus.k_len;
          cnt_d   = '0;
        end
      end
      StClr: begin
        state_d = StLoadW;
        cnt_d   = '0;
      end
      StLoadW: begin
        if (cnt_q == TW'(N - 1)) begin
          cnt_d   = '0;
          state_d = (k_q == '0) ? StDone : StRun;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StRun: begin
        if (cnt_q == run_last) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef SAC_ABORT_EN
    if (bus.abort && (state_q inside {StClr, StLoadW, StRun})) begin
      state_d = StDone;
      cnt_d   = '0;
    end
`endif
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    logic [TW-1:0] ke;
    logic [TW-1:0] lo;
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
    pe_clear_d = (state_d == StClr);
    wc_d       = (state_d == StLoadW);
    wa_d       = wc_d ? cnt_d[NW-1:0] : '0;
    sen_d      = '0;
    sad_d      = '0;
    rv_d       = '0;
    ri_d       = '0;
    ke         = TW'(k_d);
    lo         = '0;
    if (state_d == StRun) begin
      for (int unsigned r = 0; r < N; r++) begin
        lo = TW'(r);
        if (cnt_d >= lo && cnt_d < ke + lo) begin
          sen_d[r]          = 1'b1;
          sad_d[r*AW +: AW] = AW'(cnt_d - lo);
        end
      end
      for (int unsigned c = 0; c < N; c++) begin
        lo = TW'(N + c);
        if (cnt_d >= lo && cnt_d < ke + lo) begin
          rv_d[c]          = 1'b1;
          ri_d[c*AW +: AW] = AW'(cnt_d - lo);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pe_clear_q <= 1'b0;
      wc_q       <= 1'b0;
      wa_q       <= '0;
      sen_q      <= '0;
      sad_q      <= '0;
      rv_q       <= '0;
      ri_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pe_clear_q <= pe_clear_d;
      wc_q       <= wc_d;
      wa_q       <= wa_d;
      sen_q      <= sen_d;
      sad_q      <= sad_d;
      rv_q       <= rv_d;
      ri_q       <= ri_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pe_clear       = pe_clear_q;
  assign bus.weight_control = wc_q;
  assign bus.w_rd_addr      = wa_q;
  assign bus.subj_rd_en     = sen_q;
  assign bus.subj_rd_addr   = sad_q;
  assign bus.res_valid      = rv_q;
  assign bus.res_idx        = ri_q;

endmodule
